// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder feeding one bit pair per cycle through a full_add cell.
// Operands and result move over valid/ready handshakes; sum/cout hold until the next completion.
module full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx;
    logic [CW-1:0]    cnt;
    logic             carry, s, c, last;

    full_add u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(s), .co(c));

    // new sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts
    assign sum_nx   = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
    assign last     = cnt == CW'(WIDTH - 1);
    assign in_ready = state == IDLE;
    assign busy     = state == RUN;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && in_valid)  ? RUN  :
                   (state == RUN  && last)      ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= state_nx == DONE;
            if (state == IDLE && in_valid) begin
                a_sr   <= a;
                b_sr   <= b;
                carry  <= cin;
                cnt    <= '0;
                sum_sr <= '0;
            end
            if (state == RUN) begin
                sum_sr <= sum_nx;
                carry  <= c;
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                cnt    <= cnt + CW'(1);
            end
            if (state == RUN && last) begin
                sum  <= sum_nx;
                cout <= c;
            end
        end
    end
endmodule
